// File: rtl/hls_run_controller.sv
// Run sequencer for a Bambu HLS core: resets and starts the core, measures start-to-done
// latency per run and streams one registered result per run over valid/ready.
module hls_run_controller #(
    parameter int unsigned N_RUNS   = 1,
    parameter int unsigned CYC_W    = 32,
    parameter int unsigned TIMEOUT  = 200000000,
    parameter int unsigned RST_HOLD = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    output logic             core_reset,
    output logic             core_start_port,
    input  logic             core_done_port,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CYC_W-1:0] res_cycles,
    output logic [1:0]       res_status,
    output logic [15:0]      res_index,
    output logic             campaign_done,
    output logic             campaign_err
);
    localparam logic [CYC_W-1:0] TimeoutC  = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] HoldLastC = CYC_W'(RST_HOLD - 1);
    localparam logic [15:0]      LastRunC  = 16'(N_RUNS - 1);
    localparam logic [1:0]       StatusOk  = 2'b01;
    localparam logic [1:0]       StatusTmo = 2'b10;

    typedef enum logic [2:0] {StIdle, StRst, StStart, StWait, StReport, StDone} state_e;

    state_e           r_state, w_next;
    logic [CYC_W-1:0] r_cnt, w_cnt_d, w_cnt_inc, w_cnt_sat;
    logic [CYC_W-1:0] r_cycles, w_cycles_d;
    logic [1:0]       r_status, w_status_d;
    logic [15:0]      r_index, w_index_d;
    logic             r_err, w_err_d;
    logic             r_core_reset, r_start, r_busy, r_valid, r_cdone;
    logic             w_timeout, w_hs, w_last;

    // The counter doubles as the reset-hold timer in RST and the latency counter in WAIT.
    assign w_cnt_inc = r_cnt + CYC_W'(1);
    assign w_timeout = (w_cnt_inc >= TimeoutC);
    assign w_cnt_sat = w_timeout ? TimeoutC : w_cnt_inc;
    assign w_hs      = r_valid & res_ready;
    assign w_last    = (r_status == StatusTmo) || (r_index == LastRunC);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_cycles     <= '0;
            r_status     <= 2'b00;
            r_index      <= '0;
            r_err        <= 1'b0;
            r_core_reset <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_cdone      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_d;
            r_cycles     <= w_cycles_d;
            r_status     <= w_status_d;
            r_index      <= w_index_d;
            r_err        <= w_err_d;
            // Flags are registered from the next state so they line up with r_state.
            r_core_reset <= (w_next != StRst);
            r_start      <= (w_next == StStart);
            r_busy       <= (w_next != StIdle);
            r_valid      <= (w_next == StReport);
            r_cdone      <= (w_next == StDone);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:   if (go) w_next = StRst;
            StRst:    if (r_cnt == HoldLastC) w_next = StStart;
            StStart:  w_next = core_done_port ? StReport : StWait;
            StWait:   if (core_done_port || w_timeout) w_next = StReport;
            StReport: if (w_hs) w_next = w_last ? StDone : StRst;
            StDone:   w_next = StIdle;
            default:  w_next = StIdle;
        endcase
    end

    always_comb begin
        w_cnt_d    = r_cnt;
        w_cycles_d = r_cycles;
        w_status_d = r_status;
        w_index_d  = r_index;
        w_err_d    = r_err;
        case (r_state)
            StIdle: begin
                if (go) begin
                    w_cnt_d   = '0;
                    w_index_d = '0;
                    w_err_d   = 1'b0;
                end
            end
            StRst: w_cnt_d = (r_cnt == HoldLastC) ? CYC_W'(1) : w_cnt_inc;
            StStart: begin
                if (core_done_port) begin
                    w_cycles_d = CYC_W'(1);
                    w_status_d = StatusOk;
                end
            end
            StWait: begin
                w_cnt_d = w_cnt_sat;
                // Done takes priority over a timeout in the same cycle.
                if (core_done_port) begin
                    w_cycles_d = w_cnt_sat;
                    w_status_d = StatusOk;
                end else if (w_timeout) begin
                    w_cycles_d = TimeoutC;
                    w_status_d = StatusTmo;
                    w_err_d    = 1'b1;
                end
            end
            StReport: begin
                if (w_hs && !w_last) begin
                    w_cnt_d   = '0;
                    w_index_d = r_index + 16'd1;
                end
            end
            default: ;
        endcase
    end

    assign core_reset      = r_core_reset;
    assign core_start_port = r_start;
    assign busy            = r_busy;
    assign res_valid       = r_valid;
    assign res_cycles      = r_cycles;
    assign res_status      = r_status;
    assign res_index       = r_index;
    assign campaign_done   = r_cdone;
    assign campaign_err    = r_err;

endmodule

// File: doc/hls_run_controller.md
Name: hls_run_controller

Overview:
- Synthesizable run sequencer that sits directly upstream of a Bambu-generated HLS top (e.g. `main`) and drives its control handshake.
- Per run: holds the core in reset, pulses `start_port`, waits for `done_port`, and measures the latency in cycles.
- Each run result goes to a downstream consumer (logger/UART) over a valid/ready interface.
- Replaces the simulation-only start/done/timeout logic so that cycle counts can be measured on the Artix-7 board.

Parameters:
- N_RUNS, 1: number of runs per campaign (1..65535).
- CYC_W, 32: width of the cycle counter and result.
- TIMEOUT, 200000000: maximum cycles per run before abort (must fit in CYC_W).
- RST_HOLD, 2: cycles the core reset is held asserted before each start (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  campaign request; sampled only in IDLE.
- core_reset  out  1  active-low reset to the HLS core.
- core_start_port  out  1  one-cycle start pulse to the core.
- core_done_port  in  1  core completion, sampled each rising edge.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_cycles  out  CYC_W  measured latency of the run.
- res_status  out  2  01 = completed, 10 = timeout, 00 = invalid.
- res_index  out  16  run number, 0-based.
- campaign_done  out  1  one-cycle pulse when the campaign ends.
- campaign_err  out  1  sticky: a timeout occurred; cleared on the next accepted go.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE.
  - core_reset=0 (core held in reset).
  - core_start_port=0, res_valid=0, res_cycles=0, res_status=00, res_index=0.
  - campaign_done=0, campaign_err=0, counter=0.
- All outputs are registered.
- IDLE:
  - core_reset=1.
  - go=1 → RST, clear run index, clear campaign_err.
- RST:
  - core_reset=0 for exactly RST_HOLD cycles, then → START.
- START (exactly one cycle):
  - core_reset=1, core_start_port=1, counter loaded with 1.
  - If core_done_port=1 this same cycle → REPORT with cycles=1.
  - Otherwise → WAIT.
- WAIT:
  - Counter increments by 1 each cycle.
  - core_done_port=1 → capture the counter value incremented by 1, so done on the first cycle after start gives 2; status 01 → REPORT.
  - Counter reaches TIMEOUT without done → res_cycles=TIMEOUT, status 10, campaign_err=1 → REPORT.
  - Done and timeout in the same cycle: done wins (status 01).
- REPORT:
  - res_valid=1; res_cycles, res_status and res_index are stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready: res_valid drops the next cycle, then:
    - Status was timeout, or res_index=N_RUNS-1 → DONE.
    - Otherwise → res_index+1, RST.
- DONE:
  - campaign_done=1 for one cycle → IDLE.
- Counter saturates at TIMEOUT and never wraps. core_done_port is ignored outside START and WAIT.
- go is ignored while busy=1; a go asserted in the DONE cycle is ignored.
- Reset mid-run: immediate return to the reset values. The core sees core_reset=0 asynchronously; no partial result is emitted.

Test Plan:
- N_RUNS=1; core raises done 10 cycles after start → res_cycles=11, status 01, index 0, campaign_done one cycle after handshake, campaign_err=0.
- N_RUNS=3; done latencies 5, 1, 7; res_ready tied high → results 6, 2, 8, indices 0, 1, 2; core_reset low for 2 cycles before each start.
- done held high during START → res_cycles=1, status 01.
- TIMEOUT=20, done never asserted → res_cycles=20, status 10, campaign_err=1, campaign ends after run 0 even with N_RUNS=3.
- res_ready held low for 15 cycles in REPORT → res_valid stays 1 and all fields stable; one-cycle handshake on release; go pulses during the campaign have no effect.
- reset asserted during WAIT → all outputs reach reset values without waiting for a clock; after release, go starts a fresh campaign with res_index=0.
